// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state encoding and default sizing for the memory arbiter
package rr_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} arb_state_t;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_DEPTH = 1024;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker starting the search just after the last grant
module rr_pick import rr_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_id,
  output logic               any
);
  logic [IW-1:0] j;
  // scan from the farthest candidate to the nearest so the nearest requester after last wins
  always_comb begin
    j = '0;
    gnt_id = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = IW'((int'(last) + i) % NUM_REQ);
      if (req[j]) gnt_id = j;
    end
  end
  assign any = |req;
  assign gnt = any ? NUM_REQ'(1) << gnt_id : '0;
endmodule

// File: rtl/rr_mem_arbiter.sv
// rr_mem_arbiter: round-robin scheduler sharing one single-port memory between request FIFOs
module rr_mem_arbiter import rr_arb_pkg::*; #(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NUM_REQ-1:0]       empty_i,
  input  logic [NUM_REQ-1:0]       pop_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] pop_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] pop_wdata_i,
  output logic [NUM_REQ-1:0]       pop_o,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [NUM_REQ-1:0]       arb_wr_ack,
  output logic [NUM_REQ-1:0]       arb_rdata_ack,
  output logic [NUM_REQ-1:0]       arb_err,
  output logic [DATA_W-1:0]        arb_rdata,
  output logic [IW-1:0]            grant_id
);
  arb_state_t state_q;
  logic [IW-1:0] last_q, w_q, gnt_id;
  logic [NUM_REQ-1:0] gnt, w_oh, wr_ack_q, rd_ack_q, err_pulse_q;
  logic any, txn_write_q, err_q, mem_en_q, mem_we_q, sel_ok, sel_wr;
  logic [ADDR_W-1:0] sel_addr, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rdata_q;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(~empty_i),
    .last(last_q),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .any(any)
  );
  assign sel_addr = pop_addr_i[gnt_id*ADDR_W +: ADDR_W];
  assign sel_wr = pop_write_i[gnt_id];
  assign sel_ok = sel_addr < ADDR_W'(MEM_DEPTH);
  assign w_oh = NUM_REQ'(1) << w_q;
  assign pop_o = (state_q == IDLE && !PRESET) ? gnt : '0;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign arb_wr_ack = wr_ack_q;
  assign arb_rdata_ack = rd_ack_q;
  assign arb_err = err_pulse_q;
  assign arb_rdata = rdata_q;
  assign grant_id = w_q;
  // one transaction at a time: grant, access, optional read wait, acknowledge; strobes are registered one-cycle pulses
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      w_q <= '0;
      txn_write_q <= 1'b0;
      err_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      wr_ack_q <= '0;
      rd_ack_q <= '0;
      err_pulse_q <= '0;
      rdata_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      wr_ack_q <= '0;
      rd_ack_q <= '0;
      err_pulse_q <= '0;
      case (state_q)
        IDLE: if (any) begin
          state_q <= ACCESS;
          last_q <= gnt_id;
          w_q <= gnt_id;
          txn_write_q <= sel_wr;
          err_q <= !sel_ok;
          mem_en_q <= sel_ok;
          mem_we_q <= sel_ok && sel_wr;
          mem_addr_q <= sel_ok ? sel_addr : '0;
          mem_wdata_q <= (sel_ok && sel_wr) ? pop_wdata_i[gnt_id*DATA_W +: DATA_W] : '0;
        end
        ACCESS: if (txn_write_q || err_q) begin
          state_q <= RESP;
          wr_ack_q <= txn_write_q ? w_oh : '0;
          rd_ack_q <= txn_write_q ? '0 : w_oh;
          err_pulse_q <= err_q ? w_oh : '0;
        end else state_q <= RDWAIT;
        RDWAIT: begin
          state_q <= RESP;
          rdata_q <= mem_rdata;
          rd_ack_q <= w_oh;
        end
        default: begin
          state_q <= IDLE;
          err_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rr_mem_arbiter.sv
// tb_rr_mem_arbiter: randomized and directed check of the round-robin memory arbiter against a transaction model
module tb_rr_mem_arbiter;
  localparam int N = 4, AW = 32, DW = 32, DEPTH = 1024, FD = 16;
  typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} txn_t;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic [N-1:0] empty_i = '1, pop_write_i = '0, pop_o, arb_wr_ack, arb_rdata_ack, arb_err;
  logic [N*AW-1:0] pop_addr_i = '0;
  logic [N*DW-1:0] pop_wdata_i = '0;
  logic mem_en, mem_we, mem_init = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0, arb_rdata;
  logic [1:0] grant_id;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  txn_t fifo_mem [N][FD];
  int head [N], tail [N], ack_cnt [N];
  int last = N - 1, vectors = 0, miscompares = 0;
  logic [DW-1:0] exp_rdata = '0;

  rr_mem_arbiter dut (
    .PCLK(PCLK), .PRESET(PRESET), .empty_i(empty_i), .pop_write_i(pop_write_i),
    .pop_addr_i(pop_addr_i), .pop_wdata_i(pop_wdata_i), .pop_o(pop_o),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_wr_ack(arb_wr_ack), .arb_rdata_ack(arb_rdata_ack),
    .arb_err(arb_err), .arb_rdata(arb_rdata), .grant_id(grant_id)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i) * 32'h9E3779B9;
      mem_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fifo_mem[k][tail[k] % FD] = '{wr: wr, addr: a, data: d};
    tail[k]++;
  endtask

  task automatic drive_heads();
    for (int k = 0; k < N; k++) begin
      txn_t t = fifo_mem[k][head[k] % FD];
      empty_i[k] = head[k] == tail[k];
      pop_write_i[k] = t.wr;
      pop_addr_i[k*AW +: AW] = t.addr;
      pop_wdata_i[k*DW +: DW] = t.data;
    end
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    last = N - 1;
    exp_rdata = '0;
    @(negedge PCLK);
  endtask

  // entered just after a negedge while the arbiter is idle; returns at the next idle negedge
  task automatic one_txn(output bit done);
    int w = -1;
    txn_t t;
    logic [N-1:0] oh;
    bit ok;
    drive_heads();
    #1;
    for (int i = 1; i <= N; i++) if (w < 0 && head[(last + i) % N] != tail[(last + i) % N]) w = (last + i) % N;
    if (w < 0) begin
      chk("pop_idle", pop_o, 0);
      done = 1'b1;
      return;
    end
    done = 1'b0;
    oh = N'(1) << w;
    t = fifo_mem[w][head[w] % FD];
    ok = t.addr < DEPTH;
    chk("pop", pop_o, oh);
    @(posedge PCLK);
    #1 head[w]++;
    drive_heads();
    last = w;
    @(negedge PCLK);
    chk("mem_en", mem_en, ok);
    if (ok) begin
      chk("mem_we", mem_we, t.wr);
      chk("mem_addr", mem_addr, t.addr);
      if (t.wr) chk("mem_wdata", mem_wdata, t.data);
    end
    chk("pop_busy", pop_o, 0);
    chk("ack_early", {arb_wr_ack, arb_rdata_ack, arb_err}, 0);
    if (ok && t.wr) ref_mem[t.addr[9:0]] = t.data;
    if (ok && !t.wr) begin
      @(negedge PCLK);
      chk("ack_rdwait", {arb_wr_ack, arb_rdata_ack, arb_err, mem_en}, 0);
      exp_rdata = ref_mem[t.addr[9:0]];
    end
    @(negedge PCLK);
    chk("wr_ack", arb_wr_ack, t.wr ? oh : '0);
    chk("rd_ack", arb_rdata_ack, t.wr ? '0 : oh);
    chk("err", arb_err, ok ? '0 : oh);
    chk("rdata", arb_rdata, exp_rdata);
    chk("grant_id", grant_id, w);
    chk("mem_en_resp", mem_en, 0);
    for (int k = 0; k < N; k++) if (arb_wr_ack[k] || arb_rdata_ack[k]) ack_cnt[k]++;
    @(negedge PCLK);
  endtask

  task automatic drain();
    bit d = 1'b0;
    int guard = 0;
    while (!d && guard < 100) begin
      one_txn(d);
      guard++;
    end
    chk("drain_bound", d, 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i) * 32'h9E3779B9;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
      ack_cnt[k] = 0;
    end
    do_reset();
    repeat (10) begin
      chk("reset_idle", {pop_o, mem_en, mem_we, mem_addr, arb_wr_ack, arb_rdata_ack, arb_err, grant_id}, 0);
      chk("reset_data", {mem_wdata, arb_rdata}, 0);
      @(negedge PCLK);
    end
    push(2, 1'b1, 32'h10, 32'hDEADBEEF);
    drain();
    push(1, 1'b0, 32'h10, 32'h0);
    drain();
    chk("rdata_deadbeef", arb_rdata, 32'hDEADBEEF);
    do_reset();
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
    for (int k = 0; k < N; k++) begin
      push(k, 1'b1, AW'(32 + k), $urandom);
      push(k, 1'b0, AW'(32 + k), $urandom);
    end
    drain();
    for (int k = 0; k < N; k++) chk("acks_per_port", ack_cnt[k], 2);
    push(3, 1'b0, 32'd1024, 32'h0);
    drain();
    push(0, 1'b1, 32'd1023, 32'h0BADF00D);
    push(0, 1'b0, 32'd1023, 32'h0);
    drain();
    push(0, 1'b0, 32'd5, 32'h0);
    drive_heads();
    #1 chk("rst_pop", pop_o, 4'b0001);
    @(posedge PCLK);
    #1 head[0]++;
    drive_heads();
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    last = N - 1;
    exp_rdata = '0;
    repeat (3) begin
      @(negedge PCLK);
      chk("rst_no_ack", {arb_wr_ack, arb_rdata_ack, arb_err, mem_en, arb_rdata}, 0);
    end
    push(2, 1'b1, 32'd6, 32'h12345678);
    push(2, 1'b0, 32'd6, 32'h0);
    drain();
    repeat (25) begin
      for (int k = 0; k < N; k++) begin
        int cnt = int'($urandom_range(0, 3));
        for (int e = 0; e < cnt; e++) begin
          logic [AW-1:0] a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1024, 1100)) : AW'($urandom_range(0, 31));
          push(k, 1'($urandom_range(0, 1)), a, $urandom);
        end
      end
      drain();
      repeat ($urandom_range(0, 3)) @(negedge PCLK);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_mem_arbiter.md
# rr_mem_arbiter

Round-robin scheduler that shares one single-port memory between `NUM_REQ` APB slave interconnect ports. It pops one transaction at a time from the per-port request FIFOs (first-word-fall-through), performs the memory write or read, and returns a one-cycle acknowledge, plus read data, to the originating port. It sits between the request FIFOs and the memory, and drives the `arb_rdata`/`arb_rdata_ack` inputs of each interconnect.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_DEPTH`, 1024: number of words; a legal address satisfies `addr < MEM_DEPTH`.
- `PCLK` in 1: single clock; all logic is on the rising edge.
- `PRESET` in 1: synchronous, active-high reset.
- `empty_i` in NUM_REQ: per-FIFO empty flag.
- `pop_write_i` in NUM_REQ: head-entry write flag (1 = write).
- `pop_addr_i` in NUM_REQ*ADDR_W: head-entry address; packed, port k at `[k*ADDR_W +: ADDR_W]`.
- `pop_wdata_i` in NUM_REQ*DATA_W: head-entry write data; packed the same way.
- `pop_o` out NUM_REQ: one-hot, one-cycle pop strobe.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after a read `mem_en`.
- `arb_wr_ack` out NUM_REQ: one-hot, one-cycle write-complete pulse.
- `arb_rdata_ack` out NUM_REQ: one-hot, one-cycle read-complete pulse.
- `arb_err` out NUM_REQ: one-cycle pulse for an out-of-range address; always coincides with the matching ack.
- `arb_rdata` out DATA_W: registered read data; shared by all ports.
- `grant_id` out $clog2(NUM_REQ): index of the current or last grant, for debug.

## Operation
- States: IDLE, ACCESS, RDWAIT, RESP.
- **IDLE**
  - If any `empty_i[k]==0`: pick the winner `w` by round-robin, starting the search at `last_grant+1` modulo NUM_REQ.
  - Assert `pop_o[w]` in the same cycle (Mealy output).
  - Latch write flag, address and write data into `txn_*` registers.
  - Set `last_grant<=w` and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - If `txn_addr < MEM_DEPTH`: drive `mem_en=1`, `mem_we=txn_write`, `mem_addr=txn_addr`, `mem_wdata=txn_wdata`.
  - Write → RESP. Read → RDWAIT.
  - Out-of-range: no memory access; set `err_flag`; go to RESP.
- **RDWAIT**: `arb_rdata <= mem_rdata`; go to RESP.
- **RESP**
  - Pulse `arb_wr_ack[w]` for a write, or `arb_rdata_ack[w]` for a read.
  - Pulse `arb_err[w]` if `err_flag` is set; an erroneous read leaves `arb_rdata` unchanged.
  - Clear `err_flag` and return to IDLE.
- Exactly one transaction is in flight. No new pop is issued before returning to IDLE.
- Fairness: after a grant to port w, port w has the lowest priority. Any non-empty port is granted within NUM_REQ grants.

## Timing
- Reset values: state IDLE, `last_grant=NUM_REQ-1` (so port 0 wins first), and every output 0, including `arb_rdata` and `grant_id`.
- Reset mid-operation:
  - Immediate return to IDLE; no ack is issued.
  - An entry already popped is dropped. The interconnect shares `PRESET` and abandons its own transfer.
- Pop at cycle t; `mem_en` at t+1.
- Write: `arb_wr_ack` at t+2. Throughput is one write per 3 cycles.
- Read: `mem_rdata` sampled at the end of t+2; `arb_rdata_ack` with valid `arb_rdata` at t+3. Throughput is one read per 4 cycles.
- Error transaction: ack plus err at t+2, with no `mem_en`.
- `arb_rdata` holds its value until the next successful read capture.
- `empty_i` is sampled only in IDLE. A FIFO that becomes non-empty during a transaction competes at the next IDLE.
- All requesters non-empty simultaneously: grant order is 0,1,2,3,0,…
- A single active requester is re-granted back-to-back every 3 or 4 cycles.

## Structure
- Package `rr_arb_pkg`: state enum `arb_state_t` {IDLE, ACCESS, RDWAIT, RESP} and default parameter constants.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[NUM_REQ]`, `last`.
  - Outputs: one-hot `gnt`, index `gnt_id`, `any`.
  - Reused by other arbiters in the design.
- Top module: FSM, transaction registers, output muxing.

## Test plan
- Reset then idle: all outputs stay 0 for 10 cycles with all `empty_i=1`.
- Port 2 writes 0xDEADBEEF to address 0x10: `pop_o=4'b0100` at t; `mem_en=1`, `mem_we=1`, `mem_addr=0x10` at t+1; `arb_wr_ack=4'b0100` at t+2.
- Port 1 then reads address 0x10, with the memory model returning 0xDEADBEEF: `arb_rdata_ack=4'b0010` at t+3 with `arb_rdata=0xDEADBEEF`.
- All four FIFOs hold 2 entries each: grants run 0,1,2,3,0,1,2,3, and each port is acked twice.
- Port 3 reads address 1024 with `MEM_DEPTH=1024`: no `mem_en`; `arb_rdata_ack[3]` and `arb_err[3]` at t+2; `arb_rdata` unchanged.
- Assert `PRESET` during RDWAIT of a read: state returns to IDLE, no ack is issued, and the next grant proceeds normally.
